// File: rtl/sv_status_tracker.sv
// Multi-channel IDLE/BUSY/DONE/ERROR status tracker. It applies only legal transitions,
// flags illegal requests, counts transitions per channel and drives aggregate summary outputs.
module sv_status_tracker #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             upd_valid,
    input  logic [2*NUM_CH-1:0]           upd_state,
    input  logic [NUM_CH-1:0]             err_clr,
    input  logic                          cnt_clr,
    output logic [2*NUM_CH-1:0]           state_out,
    output logic [NUM_CH-1:0]             chg_pulse,
    output logic [NUM_CH-1:0]             illegal_flag,
    output logic [CNT_W*NUM_CH-1:0]       trans_cnt,
    output logic                          any_error,
    output logic                          all_idle,
    output logic [$clog2(NUM_CH+1)-1:0]   busy_count
);

    localparam int BC_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    // Transition table. Same-state requests are screened out before this is consulted.
    function automatic logic is_legal(input state_e cur, input state_e nxt);
        logic ok;
        ok = 1'b0;
        case (cur)
            ST_IDLE:  ok = (nxt == ST_BUSY);
            ST_BUSY:  ok = (nxt == ST_DONE) || (nxt == ST_ERROR);
            ST_DONE:  ok = (nxt == ST_IDLE) || (nxt == ST_BUSY);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_e              state_q, state_d;
            state_e              req;
            logic                chg_q, chg_d;
            logic                flag_q, flag_d;
            logic [CNT_W-1:0]    cnt_q, cnt_d;

            assign req = state_e'(upd_state[2*gi +: 2]);

            always_comb begin
                state_d = state_q;
                chg_d   = 1'b0;
                flag_d  = flag_q;
                // err_clr owns the channel this cycle; any concurrent update is dropped silently.
                if (err_clr[gi]) begin
                    flag_d = 1'b0;
                    if (state_q == ST_ERROR) begin
                        state_d = ST_IDLE;
                        chg_d   = 1'b1;
                    end
                end else if (upd_valid[gi] && (req != state_q)) begin
                    if (is_legal(state_q, req)) begin
                        state_d = req;
                        chg_d   = 1'b1;
                    end else begin
                        flag_d = 1'b1;
                    end
                end
            end

            // A clear wins over a same-cycle change, so that change is not counted.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (chg_d && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    chg_q   <= 1'b0;
                    flag_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    chg_q   <= chg_d;
                    flag_q  <= flag_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign state_out[2*gi +: 2]       = state_q;
            assign chg_pulse[gi]              = chg_q;
            assign illegal_flag[gi]           = flag_q;
            assign trans_cnt[CNT_W*gi +: CNT_W] = cnt_q;
        end
    endgenerate

    always_comb begin
        any_error  = 1'b0;
        all_idle   = 1'b1;
        busy_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_out[2*c +: 2] == ST_ERROR) any_error = 1'b1;
            if (state_out[2*c +: 2] != ST_IDLE)  all_idle  = 1'b0;
            if (state_out[2*c +: 2] == ST_BUSY)  busy_count = busy_count + BC_W'(1);
        end
    end

endmodule
